pipe_rr_arbiter: RTL

PIPE_RR_ARBITER -- requirements
Module: pipe_rr_arbiter

---
 rtl/pipe_rr_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/pipe_rr_arbiter.sv
// Round-robin arbiter with burst locking, feeding a 2-slot output buffer.
// Each buffered token carries its data, last flag and source index together.
module pipe_rr_arbiter #(
  parameter string Name      = "",
  parameter int    Width     = 8,
  parameter int    NumInputs = 4,
  localparam int   SelW      = (NumInputs > 1) ? $clog2(NumInputs) : 1
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NumInputs*Width-1:0] in_data,
  input  logic [NumInputs-1:0]       in_last,
  input  logic [NumInputs-1:0]       in_valid,
  output logic [NumInputs-1:0]       in_bp,
  output logic [Width-1:0]           out_data,
  output logic                       out_last,
  output logic [SelW-1:0]            out_sel,
  output logic                       out_valid,
  input  logic                       out_bp
);

  if (NumInputs < 2 || NumInputs > 8 || Width < 1) begin : g_param_check
    $error("pipe_rr_arbiter %s: unsupported parameters", Name);
  end

  // Handshake: a token moves on a rising edge where its valid is 1 and its bp is 0.
  // Valid never depends on bp; bp may depend on valid.

  typedef enum logic {
    ST_IDLE,
    ST_LOCKED
  } state_t;

  state_t            state_q, state_d;
  logic [SelW-1:0]   lock_q, lock_d;
  logic [SelW-1:0]   ptr_q, ptr_d;

  logic              s1_valid, s2_valid;
  logic [Width-1:0]  s1_data, s2_data;
  logic              s1_last, s2_last;
  logic [SelW-1:0]   s1_sel, s2_sel;

  logic [1:0]        count;
  logic              accept;
  logic              pop;
  logic              xfer;
  logic              gnt_valid;
  logic [SelW-1:0]   gnt_idx;
  logic [SelW-1:0]   idx_s;
  logic [Width-1:0]  gnt_data;
  logic              gnt_last;

  assign count  = {1'b0, s1_valid} + {1'b0, s2_valid};
  assign accept = (count < 2'd2);
  assign pop    = s1_valid && !out_bp;
  assign xfer   = resetn && accept && gnt_valid;

  // Lowest rotated offset from ptr wins, hence the descending scan.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx_s     = '0;
    if (state_q == ST_LOCKED) begin
      gnt_valid = in_valid[lock_q];
      gnt_idx   = lock_q;
    end else begin
      for (int k = NumInputs - 1; k >= 0; k--) begin
        idx_s = SelW'((int'(ptr_q) + k) % NumInputs);
        if (in_valid[idx_s]) begin
          gnt_valid = 1'b1;
          gnt_idx   = idx_s;
        end
      end
    end
  end

  always_comb begin
    gnt_data = '0;
    gnt_last = 1'b0;
    for (int i = 0; i < NumInputs; i++) begin
      if (gnt_idx == SelW'(i)) begin
        gnt_data = in_data[i*Width +: Width];
        gnt_last = in_last[i];
      end
    end
  end

  always_comb begin
    in_bp = '1;
    if (xfer) in_bp[gnt_idx] = 1'b0;
  end

  always_comb begin
    state_d = state_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    if (xfer) begin
      ptr_d = (gnt_idx == SelW'(NumInputs - 1)) ? '0 : gnt_idx + SelW'(1);
      if (state_q == ST_IDLE && !gnt_last) begin
        state_d = ST_LOCKED;
        lock_d  = gnt_idx;
      end else if (state_q == ST_LOCKED && gnt_last) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      lock_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
      ptr_q   <= ptr_d;
    end
  end

  // Slot 2 is only ever occupied behind an occupied slot 1, so a push with a
  // simultaneous pop can only happen at count 1 and always lands in slot 1.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else if (xfer && pop) begin
      s1_data <= gnt_data;
      s1_last <= gnt_last;
      s1_sel  <= gnt_idx;
    end else if (pop) begin
      s1_valid <= s2_valid;
      s1_data  <= s2_data;
      s1_last  <= s2_last;
      s1_sel   <= s2_sel;
      s2_valid <= 1'b0;
    end else if (xfer) begin
      if (!s1_valid) begin
        s1_valid <= 1'b1;
        s1_data  <= gnt_data;
        s1_last  <= gnt_last;
        s1_sel   <= gnt_idx;
      end else begin
        s2_valid <= 1'b1;
        s2_data  <= gnt_data;
        s2_last  <= gnt_last;
        s2_sel   <= gnt_idx;
      end
    end
  end

  assign out_valid = s1_valid;
  assign out_data  = s1_data;
  assign out_last  = s1_last;
  assign out_sel   = s1_sel;

endmodule
